// File: rtl/chain_chk_pkg.sv
// Shared types and constants for the chain checker: FSM states, PRBS7 taps/seed, mode codes.
package chain_chk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    LAUNCH,
    MEASURE,
    PRBS_WAIT,
    PRBS_SYNC,
    PRBS_RUN,
    DONE
  } state_t;

  // x^7 + x^6 + 1 on a left-shifting register: feedback taps are bits 6 and 5
  localparam int         PRBS_TAP_HI   = 6;
  localparam int         PRBS_TAP_LO   = 5;
  localparam logic [6:0] PRBS_SEED     = 7'h7F;
  localparam int         PRBS_SYNC_LEN = 7;

  localparam logic MODE_LAT  = 1'b0;
  localparam logic MODE_PRBS = 1'b1;

  function automatic logic prbs7_fb(input logic [6:0] s);
    return s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO];
  endfunction

endpackage

// File: rtl/prbs7_checker.sv
// Self-synchronising PRBS7 receiver: rx shift register, next-bit prediction,
// saturating mismatch counter and lock-up (all-zero rx) detection.
module prbs7_checker
  import chain_chk_pkg::*;
#(
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          shift,
  input  logic          check,
  input  logic          zero_chk,
  input  logic          bit_in,
  output logic [EW-1:0] err_count
);

  localparam logic [EW-1:0] ERR_MAX = '1;

  logic [6:0] rx;
  logic [6:0] rx_nxt;
  logic       mismatch;

  assign rx_nxt   = {rx[5:0], bit_in};
  assign mismatch = bit_in != prbs7_fb(rx);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rx        <= PRBS_SEED;
      err_count <= '0;
    end else begin
      if (shift) begin
        rx <= rx_nxt;
      end
      // An all-zero rx would predict zeros forever and hide a dead chain
      if (zero_chk && shift && rx_nxt == 7'd0) begin
        err_count <= ERR_MAX;
      end else if (check && mismatch && err_count != ERR_MAX) begin
        err_count <= err_count + EW'(1);
      end
    end
  end

endmodule

// File: rtl/chain_checker.sv
// Drives one delay chain and either measures its latency in cycles or runs a
// PRBS7 integrity test, reporting results held until the next accepted start.
module chain_checker
  import chain_chk_pkg::*;
#(
  parameter int MAX_LAT = 255,
  parameter int CW      = 8,
  parameter int RUN_LEN = 1024,
  parameter int EW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  output logic          chain_din,
  input  logic          chain_dout,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] latency,
  output logic          timeout,
  output logic [EW-1:0] err_count,
  output logic          locked
);

  localparam int CNT_MAX = (MAX_LAT + 1 > RUN_LEN) ? MAX_LAT + 1 : RUN_LEN;
  localparam int NW      = $clog2(CNT_MAX + 1);

  localparam logic [NW-1:0] WAIT_LAST = NW'(MAX_LAT);
  localparam logic [NW-1:0] K_LAST    = NW'(MAX_LAT + 1);
  localparam logic [NW-1:0] SYNC_LAST = NW'(PRBS_SYNC_LEN - 1);
  localparam logic [NW-1:0] RUN_LAST  = NW'(RUN_LEN - 1);

  state_t        state;
  state_t        state_nxt;
  logic [NW-1:0] cnt;
  logic          hit;
  logic [6:0]    lfsr;
  logic [6:0]    lfsr_cur;
  logic          tx_bit;
  logic          prbs_nxt;
  logic          accept;

  assign accept   = (state == IDLE) && start;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  assign locked   = state == PRBS_RUN;
  assign lfsr_cur = (state == IDLE) ? PRBS_SEED : lfsr;
  assign tx_bit   = prbs7_fb(lfsr_cur);
  assign prbs_nxt = (state_nxt == PRBS_WAIT) || (state_nxt == PRBS_SYNC) ||
                    (state_nxt == PRBS_RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = (mode == MODE_PRBS) ? PRBS_WAIT : FLUSH;
      FLUSH:     if (cnt == WAIT_LAST) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = MEASURE;
      MEASURE:   if (hit || chain_dout || cnt == K_LAST) state_nxt = DONE;
      PRBS_WAIT: if (cnt == WAIT_LAST) state_nxt = PRBS_SYNC;
      PRBS_SYNC: if (cnt == SYNC_LAST) state_nxt = PRBS_RUN;
      PRBS_RUN:  if (cnt == RUN_LAST) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // cnt holds k while sampling: the LAUNCH closing edge is k=1
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      hit     <= 1'b0;
      latency <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          cnt     <= '0;
          hit     <= 1'b0;
          latency <= '0;
          timeout <= 1'b0;
        end
        FLUSH:     cnt <= (cnt == WAIT_LAST) ? NW'(1) : cnt + NW'(1);
        LAUNCH: begin
          cnt <= cnt + NW'(1);
          if (chain_dout) begin
            latency <= '0;
            hit     <= 1'b1;
          end
        end
        MEASURE: begin
          cnt <= cnt + NW'(1);
          if (!hit) begin
            if (chain_dout) begin
              latency <= CW'(cnt - NW'(1));
            end else if (cnt == K_LAST) begin
              latency <= CW'(MAX_LAT);
              timeout <= 1'b1;
            end
          end
        end
        PRBS_WAIT: cnt <= (cnt == WAIT_LAST) ? '0 : cnt + NW'(1);
        PRBS_SYNC: cnt <= (cnt == SYNC_LAST) ? '0 : cnt + NW'(1);
        PRBS_RUN:  cnt <= cnt + NW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_din <= 1'b0;
      lfsr      <= PRBS_SEED;
    end else if (prbs_nxt) begin
      chain_din <= tx_bit;
      lfsr      <= {lfsr_cur[5:0], tx_bit};
    end else begin
      chain_din <= (state_nxt == LAUNCH);
    end
  end

  prbs7_checker #(
    .EW(EW)
  ) u_prbs7_checker (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .shift    ((state == PRBS_SYNC) || (state == PRBS_RUN)),
    .check    (state == PRBS_RUN),
    .zero_chk ((state == PRBS_SYNC) && (cnt == SYNC_LAST)),
    .bit_in   (chain_dout),
    .err_count(err_count)
  );

endmodule

// File: doc/chain_checker.md
Name: chain_checker

Overview:
- Receive-side measurement engine for one `testchain` delay chain.
- Drives the chain input (`chain_din`) and observes the chain output (`chain_dout`).
- Measures the chain latency in clock cycles, or runs a PRBS7 integrity test and counts bit errors.
- One instance per chain slice, sitting between the top-level pins and the chain.

Parameters:
- MAX_LAT, 255, largest latency measurable before timeout; also the PRBS pre-sync skip length.
- CW, 8, width of `latency`; must satisfy 2^CW-1 >= MAX_LAT.
- RUN_LEN, 1024, number of compared bits in PRBS mode.
- EW, 8, width of `err_count`; the count saturates.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- mode  input  1  0 = latency measurement, 1 = PRBS test; sampled with `start`.
- chain_din  output  1  registered drive to the chain input.
- chain_dout  input  1  chain output; assumed synchronous to `clk`.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a run completes.
- latency  output  CW  measured latency; held until the next accepted `start`.
- timeout  output  1  latency run saw no edge; held.
- err_count  output  EW  PRBS mismatch count, saturating; held.
- locked  output  1  high while in PRBS_RUN.

Behaviour:
- Reset (synchronous, `rst`=1): state=IDLE. `chain_din`, `busy`, `done`, `latency`, `timeout`, `err_count`, `locked` all 0. LFSRs reset to 7'h7F.
- Reset mid-run: abort immediately; no `done` pulse.
- IDLE: `start`=1 latches `mode` and clears `latency`, `timeout` and `err_count`.
  - mode 0 -> FLUSH.
  - mode 1 -> PRBS_WAIT.
  - `start` outside IDLE is ignored.
- FLUSH: `chain_din`=0 for MAX_LAT+1 cycles, then -> LAUNCH.
- LAUNCH: `chain_din`=1 for exactly one cycle. The counter k is reset so that the first edge after `chain_din` rises is k=1. Then -> MEASURE.
- MEASURE: `chain_din`=0. Sample `chain_dout` at each edge k.
  - First k with `chain_dout`=1: `latency`=k-1, -> DONE.
  - If k-1 reaches MAX_LAT without a 1: `latency`=MAX_LAT, `timeout`=1, -> DONE.
  - Consequence: an N-flop shift chain reports N; a combinational loopback reports 0.
- PRBS TX (active in PRBS_WAIT, PRBS_SYNC and PRBS_RUN):
  - Polynomial x^7+x^6+1, seed 7'h7F.
  - Each cycle `chain_din` <= lfsr[6]^lfsr[5], and lfsr shifts left taking that bit.
  - `chain_din`=0 in all other states.
- PRBS_WAIT: MAX_LAT+1 cycles, discarding `chain_dout`, then -> PRBS_SYNC.
- PRBS_SYNC: shift 7 received bits into the rx register (self-synchronising), then -> PRBS_RUN.
- PRBS_RUN: RUN_LEN cycles.
  - Each cycle: predicted = rx[6]^rx[5]. If `chain_dout` != predicted, increment `err_count` (saturating at 2^EW-1).
  - The received bit is always shifted into rx.
  - `locked`=1 throughout. After RUN_LEN bits -> DONE.
- DONE: `done`=1 for one cycle, `busy`=0 on the following cycle, -> IDLE. Results held.
- Width and edge rules:
  - Cycle counters are sized for max(MAX_LAT+1, RUN_LEN).
  - `err_count` never wraps.
  - A chain stuck at 0 in PRBS mode yields 0 errors only if rx fills with zeros (LFSR lock-up). To cover this, PRBS_SYNC flags an all-zero rx at its exit by setting `err_count` to saturated immediately.

Decomposition:
- Package `chain_chk_pkg` holds:
  - state enum: IDLE, FLUSH, LAUNCH, MEASURE, PRBS_WAIT, PRBS_SYNC, PRBS_RUN, DONE;
  - PRBS7 tap positions and seed 7'h7F;
  - mode encoding constants.
- Natural sub-module `prbs7_checker`: rx shift register, predict/compare, saturating error counter and all-zero detect.
- TX LFSR and FSM remain in `chain_checker`.

Test Plan:
- Latency, 64-flop chain model (default params), mode 0 -> `latency`=64, `timeout`=0, `done` pulses once exactly MAX_LAT+1+1+65 cycles after `start`.
- Loopback: `chain_dout`=`chain_din` combinationally, mode 0 -> `latency`=0. Chain tied to 0 -> `latency`=255, `timeout`=1.
- PRBS, clean 64-flop chain, mode 1 -> `locked` high for 1024 cycles, `err_count`=0, `done` pulse.
- PRBS with a single bit flip injected at run cycle 100 -> `err_count`=3 (one direct mismatch plus two propagated through taps 6 and 7). Chain stuck at 0 -> `err_count`=255.
- Assert `rst` during MEASURE and PRBS_RUN -> next cycle all outputs 0, state IDLE, no `done`. Pulse `start` while `busy` -> ignored, results unaffected.
- Back-to-back runs: mode 1 then mode 0 without reset -> `err_count` cleared at second `start`, `latency` correct, `chain_din`=0 throughout FLUSH.
